// File: rtl/zc_front_end.sv
// zc_front_end: zero-crossing front end feeding the zero-point analyser.
// 16 time-ordered samples per beat -> saturated first differences (including
// across beats), deadband classification, hysteresis sign chain, and the
// aligned zero_mask / diff_out / abs_out triple. Three-stage pipeline.
// Optional feature: define ZC_DEADBAND_EN to honour the deadband port;
// without it the deadband is treated as 0 (pure sign/zero detect).

// Per-lane datapath: S1 difference + saturation, S2 classification.
module zc_lane #(
  parameter int DW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vld_s0,
  input  logic          vld_s1,
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] prev,
  input  logic          prev_ok,
  input  logic [DW-1:0] deadband,
  output logic [DW-1:0] s2_x,
  output logic [DW-1:0] s2_diff,
  output logic [1:0]    s2_cls
);
  localparam logic [1:0] CLS_ZERO = 2'd0;
  localparam logic [1:0] CLS_POS  = 2'd1;
  localparam logic [1:0] CLS_NEG  = 2'd2;

  logic [DW:0]   d_wide;
  logic [DW-1:0] d_sat;
  logic [DW-1:0] s1_x, s1_diff;
  logic [1:0]    cls;

  // Difference at DW+1 bits, clamped back to DW; no previous sample -> 0
  always_comb begin
    d_wide = {x[DW-1], x} - {prev[DW-1], prev};
    if (d_wide[DW] != d_wide[DW-1])
      d_sat = d_wide[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      d_sat = d_wide[DW-1:0];
    if (!prev_ok)
      d_sat = '0;
  end

  // S1 register: sample and saturated difference
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_x    <= '0;
      s1_diff <= '0;
    end else if (vld_s0) begin
      s1_x    <= x;
      s1_diff <= d_sat;
    end
  end

`ifdef ZC_DEADBAND_EN
  logic signed [DW:0] d_ext, db_ext;

  // Classify against +/- deadband, compared one bit wider so -deadband fits
  always_comb begin
    d_ext  = $signed({s1_diff[DW-1], s1_diff});
    db_ext = $signed({deadband[DW-1], deadband});
    cls    = CLS_ZERO;
    if (d_ext > db_ext)
      cls = CLS_POS;
    else if (d_ext < -db_ext)
      cls = CLS_NEG;
  end
`else
  logic unused_deadband;
  assign unused_deadband = ^deadband;

  // Deadband fixed at 0: classification is just sign / zero detect
  always_comb begin
    cls = CLS_ZERO;
    if (s1_diff[DW-1])
      cls = CLS_NEG;
    else if (|s1_diff)
      cls = CLS_POS;
  end
`endif

  // S2 register: class plus aligned sample and difference
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_x    <= '0;
      s2_diff <= '0;
      s2_cls  <= CLS_ZERO;
    end else if (vld_s1) begin
      s2_x    <= s1_x;
      s2_diff <= s1_diff;
      s2_cls  <= cls;
    end
  end
endmodule

module zc_front_end #(
  parameter int NUM_CHANNELS = 16,
  parameter int DATA_WIDTH   = 20
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               valid_in,
  input  logic                               resync,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0]              deadband,
  output logic                               valid_out,
  output logic [NUM_CHANNELS-1:0]            zero_mask,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] diff_out,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] abs_out
);
  localparam int N      = NUM_CHANNELS;
  localparam int DW     = DATA_WIDTH;
  localparam int STAGES = 3;

  // Sign codes share the class encoding: ZERO class == NONE sign == 0
  localparam logic [1:0] SGN_NONE = 2'd0;

  typedef enum logic {ST_UNPRIMED, ST_PRIMED} state_e;

  typedef struct packed {
    logic [N-1:0]          mask;
    logic [N-1:0][DW-1:0]  diff;
    logic [N-1:0][DW-1:0]  abs_v;
  } zc_beat_t;

  state_e               st_q, st_d;
  logic                 prev_ok;
  logic [DW-1:0]        last_sample;
  logic [STAGES:1]      vld_q;
  logic [STAGES:0]      vld_pipe;
  logic [2:1]           seed_none;
  logic [N-1:0][DW-1:0] x_in, prev_in, s2_x, s2_diff;
  logic [N-1:0][1:0]    s2_cls;
  logic [N-1:0]         lane_ok;
  logic [N-1:0]         chain_mask;
  logic [1:0]           chain_sign, held_sign;
  zc_beat_t             out_q;

  assign x_in     = data_in;
  assign vld_pipe = {vld_q, valid_in};

  // Priming state register
  always_ff @(posedge clk) begin
    if (rst) st_q <= ST_UNPRIMED;
    else     st_q <= st_d;
  end

  // Any valid beat (resync or not) leaves the block primed with its lane 15
  always_comb begin
    st_d = st_q;
    if (valid_in)
      st_d = ST_PRIMED;
  end

  // Cross-beat history is usable only when primed and not resyncing
  always_comb begin
    prev_ok = (st_q == ST_PRIMED) && !resync;
  end

  // Last sample of the most recent valid beat, feeds lane 0 of the next one
  always_ff @(posedge clk) begin
    if (rst)           last_sample <= '0;
    else if (valid_in) last_sample <= x_in[N-1];
  end

  // Pipeline valids; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_pipe[STAGES-1:0];
  end

  // Carry "seed the sign chain with NONE" alongside the beat to S3
  always_ff @(posedge clk) begin
    if (rst) begin
      seed_none <= '1;
    end else begin
      if (vld_pipe[0]) seed_none[1] <= !prev_ok;
      if (vld_pipe[1]) seed_none[2] <= seed_none[1];
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    if (g == 0) begin : g_first
      assign prev_in[g] = last_sample;
      assign lane_ok[g] = prev_ok;
    end else begin : g_rest
      assign prev_in[g] = x_in[g-1];
      assign lane_ok[g] = 1'b1;
    end

    zc_lane #(.DW(DW)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .vld_s0   (vld_pipe[0]),
      .vld_s1   (vld_pipe[1]),
      .x        (x_in[g]),
      .prev     (prev_in[g]),
      .prev_ok  (lane_ok[g]),
      .deadband (deadband),
      .s2_x     (s2_x[g]),
      .s2_diff  (s2_diff[g]),
      .s2_cls   (s2_cls[g])
    );
  end

  // Hysteresis chain lane 0 -> N-1. It reads held_sign directly, and
  // held_sign is written on the same edge the previous beat leaves S2, so
  // back-to-back beats see the freshly updated sign with no extra bypass.
  always_comb begin
    logic [1:0] run;
    run        = seed_none[2] ? SGN_NONE : held_sign;
    chain_mask = '0;
    for (int k = 0; k < N; k++) begin
      if (s2_cls[k] != SGN_NONE) begin
        chain_mask[k] = (run != SGN_NONE) && (s2_cls[k] != run);
        run           = s2_cls[k];
      end
    end
    chain_sign = run;
  end

  // S3 register: output triple and held sign; holds across gaps
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      held_sign <= SGN_NONE;
    end else if (vld_pipe[2]) begin
      out_q.mask  <= chain_mask;
      out_q.diff  <= s2_diff;
      out_q.abs_v <= s2_x;
      held_sign   <= chain_sign;
    end
  end

  assign valid_out = vld_q[STAGES];
  assign zero_mask = out_q.mask;
  assign diff_out  = out_q.diff;
  assign abs_out   = out_q.abs_v;
endmodule

// File: tb/tb_zc_front_end.sv
// Self-checking bench for zc_front_end: directed test-plan beats plus
// randomized beats against a beat-level integer reference model.
module tb_zc_front_end;
  localparam int N  = 16;
  localparam int DW = 20;
  localparam int W  = N * DW;
  localparam int SMAX = 524287;
  localparam int SMIN = -524288;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  logic          resync = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic [DW-1:0] deadband = '0;
  logic          valid_out;
  logic [N-1:0]  zero_mask;
  logic [W-1:0]  diff_out;
  logic [W-1:0]  abs_out;

  zc_front_end #(.NUM_CHANNELS(N), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .resync    (resync),
    .data_in   (data_in),
    .deadband  (deadband),
    .valid_out (valid_out),
    .zero_mask (zero_mask),
    .diff_out  (diff_out),
    .abs_out   (abs_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int           due;
    logic [N-1:0] mask;
    logic [W-1:0] diff;
    logic [W-1:0] absv;
  } exp_t;

  exp_t         q[$];
  int           bx[N];
  bit           m_primed = 0;
  int           m_last = 0;
  int           m_held = 0;   // 0 none, 1 pos, 2 neg
  int           m_db = 0;
  logic [N-1:0] h_mask = '0;
  logic [W-1:0] h_diff = '0;
  logic [W-1:0] h_abs  = '0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: whole-beat rules with plain integers
  task automatic model_beat(input bit rs);
    exp_t e;
    int   run, d, c;
    bit   have_prev;
    have_prev = m_primed && !rs;
    run    = have_prev ? m_held : 0;
    e.due  = cyc + 3;
    e.mask = '0;
    e.diff = '0;
    e.absv = '0;
    for (int k = 0; k < N; k++) begin
      if (k == 0) d = have_prev ? bx[0] - m_last : 0;
      else        d = bx[k] - bx[k-1];
      if (d > SMAX) d = SMAX;
      if (d < SMIN) d = SMIN;
      c = (d > m_db) ? 1 : ((d < -m_db) ? 2 : 0);
      if (c != 0) begin
        if (run != 0 && c != run) e.mask[k] = 1'b1;
        run = c;
      end
      e.diff[k*DW +: DW] = DW'(d);
      e.absv[k*DW +: DW] = DW'(bx[k]);
    end
    m_last   = bx[N-1];
    m_primed = 1;
    m_held   = run;
    q.push_back(e);
  endtask

  task automatic check_outputs();
    bit ev;
    ev = (q.size() > 0) && (q[0].due == cyc);
    check("valid_out", W'(valid_out), W'(ev));
    if (ev) begin
      h_mask = q[0].mask;
      h_diff = q[0].diff;
      h_abs  = q[0].absv;
      q.delete(0);
    end
    check("zero_mask", W'(zero_mask), W'(h_mask));
    check("diff_out", diff_out, h_diff);
    check("abs_out", abs_out, h_abs);
  endtask

  // One clock: check what the last edge produced, then drive the next inputs
  task automatic cycle(input bit v, input bit rs, input bit r);
    @(negedge clk);
    check_outputs();
    rst      = r;
    valid_in = v && !r;
    resync   = rs;
    for (int k = 0; k < N; k++) data_in[k*DW +: DW] = DW'(bx[k]);
    if (r) begin
      q.delete();
      m_primed = 0;
      m_last   = 0;
      m_held   = 0;
      h_mask   = '0;
      h_diff   = '0;
      h_abs    = '0;
    end else if (v) begin
      model_beat(rs);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic ramp(input int start, input int step);
    for (int k = 0; k < N; k++) bx[k] = start + step * k;
  endtask

  task automatic fill(input int v);
    for (int k = 0; k < N; k++) bx[k] = v;
  endtask

  task automatic set_db(input int v);
    deadband = DW'(v);
`ifdef ZC_DEADBAND_EN
    m_db = v;
`else
    m_db = 0;
`endif
  endtask

  task automatic rand_beat();
    int p;
    logic signed [DW-1:0] r20;
    p = m_last;
    for (int k = 0; k < N; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        r20   = DW'($urandom);
        bx[k] = int'(r20);
      end else begin
        bx[k] = p + int'($urandom_range(0, 200)) - 100;
        if (bx[k] > SMAX) bx[k] = SMAX;
        if (bx[k] < SMIN) bx[k] = SMIN;
      end
      p = bx[k];
    end
  endtask

  initial begin
    bit v, rs, r;
    fill(0);
    set_db(0);
    repeat (2) @(posedge clk);
    idle(2);                                   // first check sees reset state

    // Reset then ramp
    ramp(0, 16); cycle(1, 0, 0); idle(4);
    check("ramp_mask", W'(zero_mask), W'(16'h0000));
    check("ramp_d0", W'(diff_out[DW-1:0]), W'(20'd0));
    check("ramp_d1", W'(diff_out[2*DW-1:DW]), W'(20'd16));

    // Triangle (resync so lane 0 starts clean), then flat, then rising
    for (int k = 0; k < N; k++) bx[k] = (k < 8) ? 16 * k : 16 * (14 - k);
    cycle(1, 1, 0); idle(4);
    check("tri_mask", W'(zero_mask), W'(16'h0100));
    fill(-16); cycle(1, 0, 0); idle(4);
    check("flat_mask", W'(zero_mask), W'(16'h0000));
    ramp(0, 16); cycle(1, 0, 0); idle(4);
    check("held_neg_mask", W'(zero_mask), W'(16'h0001));

    // Cross-beat crossing, back to back
    ramp(1000 - 15 * 10, 10); cycle(1, 1, 0);
    fill(900); cycle(1, 0, 0); idle(4);
    check("xbeat_d0", W'(diff_out[DW-1:0]), W'(20'hFFF9C));
    check("xbeat_mask", W'(zero_mask), W'(16'h0001));

    // Saturation both ways
    fill(SMIN); cycle(1, 1, 0);
    fill(SMAX); cycle(1, 0, 0); idle(4);
    check("sat_pos", W'(diff_out[DW-1:0]), W'(20'h7FFFF));
    fill(SMIN); cycle(1, 0, 0); idle(4);
    check("sat_neg", W'(diff_out[DW-1:0]), W'(20'h80000));

    // Gap, then the same with resync on the falling beat
    ramp(0, 16); cycle(1, 1, 0); idle(5);
    ramp(200, -16); cycle(1, 0, 0); idle(4);
    check("gap_mask0", W'(zero_mask[0]), W'(1'b1));
    ramp(0, 16); cycle(1, 1, 0); idle(5);
    ramp(200, -16); cycle(1, 1, 0); idle(4);
    check("resync_d0", W'(diff_out[DW-1:0]), W'(20'd0));
    check("resync_mask", W'(zero_mask), W'(16'h0000));

    // Deadband / hysteresis after an established POS
    set_db(32);
    ramp(0, 64); cycle(1, 1, 0);
    bx[0] = 960 - 20; bx[1] = bx[0] + 10; bx[2] = bx[1] - 20; bx[3] = bx[2] - 40;
    for (int k = 4; k < N; k++) bx[k] = bx[3];
    cycle(1, 0, 0); idle(4);
`ifdef ZC_DEADBAND_EN
    check("db_mask", W'(zero_mask), W'(16'h0008));
`else
    check("db_mask", W'(zero_mask), W'(16'h0007));
`endif
    set_db(0);

    // Reset mid-stream: in-flight beats never appear
    ramp(5, 3); cycle(1, 0, 0);
    ramp(50, -3); cycle(1, 0, 0);
    cycle(0, 0, 1);
    idle(5);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) begin
        idle(4);
`ifdef ZC_DEADBAND_EN
        set_db(int'($urandom_range(0, 64)));
`else
        set_db(int'($urandom_range(0, 500)));
`endif
      end
      r  = ($urandom_range(0, 99) == 0);
      v  = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 15) == 0);
      rand_beat();
      cycle(v, rs, r);
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
